// File: rtl/imem_prefetch_if.sv
// Fetch-side bus of imem_prefetch: redirect, loader write port and the
// instruction output handshake.
interface imem_prefetch_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 8
);
    logic              redir_valid;
    logic [ADDR_W-1:0] redir_addr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;
    logic              out_fault;

    modport master (
        output redir_valid, redir_addr, wr_en, wr_addr, wr_data, out_ready,
        input  out_valid, out_inst, out_pc, out_fault
    );

    modport slave (
        input  redir_valid, redir_addr, wr_en, wr_addr, wr_data, out_ready,
        output out_valid, out_inst, out_pc, out_fault
    );
endinterface

// File: rtl/imem_prefetch.sv
// Sequential instruction prefetcher: word array with a LAT-stage read pipeline
// feeding a credit-limited output queue, flushed by redirects.
module imem_prefetch #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned DEPTH    = 256,
    parameter int unsigned LAT      = 2,
    parameter int unsigned QDEPTH   = 4,
    parameter int unsigned RESET_PC = 0
) (
    input logic            clk,
    input logic            rst_n,
    imem_prefetch_if.slave bus
);
    localparam int unsigned WordSpace = 2 ** (ADDR_W - 2);
    // Words beyond the addressable space can never be fetched, so don't store them.
    localparam int unsigned MemDepth  = (DEPTH < WordSpace) ? DEPTH : WordSpace;
    localparam int unsigned IdxW      = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam int unsigned PtrW      = $clog2(QDEPTH);
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_word, wr_word;
    logic              pc_in_range, wr_in_range;
    logic              flush, issue, enq, deq;
    logic [DATA_W-1:0] rd_data;
    int unsigned       inflight, occupancy;

    logic [DATA_W-1:0] mem [MemDepth];

    logic [LAT-1:0]    stg_valid_q;
    logic [LAT-1:0]    stg_fault_q;
    logic [ADDR_W-1:0] stg_pc_q   [LAT];
    logic [DATA_W-1:0] stg_data_q [LAT];

    logic [DATA_W-1:0] q_inst_q [QDEPTH];
    logic [ADDR_W-1:0] q_pc_q   [QDEPTH];
    logic [QDEPTH-1:0] q_fault_q;
    logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [PtrW:0]     count_q, count_d;

    assign pc_word     = pc_q >> 2;
    assign wr_word     = bus.wr_addr >> 2;
    assign pc_in_range = 32'(pc_word) < DEPTH;
    assign wr_in_range = 32'(wr_word) < DEPTH;
    assign rd_data     = pc_in_range ? mem[pc_word[IdxW-1:0]] : '0;

    always_comb begin
        flush    = bus.redir_valid;
        inflight = 0;
        for (int i = 0; i < LAT; i++) begin
            inflight = inflight + 32'(stg_valid_q[i]);
        end
        // Reads in flight already own a queue slot, so the queue can never overflow.
        occupancy = 32'(count_q) + inflight;
        issue     = !flush && (occupancy < QDEPTH);
        enq       = stg_valid_q[LAT-1] && !flush;
        deq       = bus.out_valid && bus.out_ready && !flush;

        pc_d = pc_q;
        if (flush) begin
            pc_d = bus.redir_addr & ~ADDR_W'(3);
        end else if (issue) begin
            pc_d = pc_q + ADDR_W'(4);
        end

        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= ResetPc;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Array is not reset; a same-edge write is seen only by later reads.
    always_ff @(posedge clk) begin
        if (bus.wr_en && wr_in_range) begin
            mem[wr_word[IdxW-1:0]] <= bus.wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stg_valid_q <= '0;
            stg_fault_q <= '0;
            for (int i = 0; i < LAT; i++) begin
                stg_pc_q[i]   <= ResetPc;
                stg_data_q[i] <= '0;
            end
        end else begin
            stg_valid_q[0] <= issue;
            stg_fault_q[0] <= !pc_in_range;
            stg_pc_q[0]    <= pc_q;
            stg_data_q[0]  <= rd_data;
            for (int i = 1; i < LAT; i++) begin
                stg_valid_q[i] <= stg_valid_q[i-1] && !flush;
                stg_fault_q[i] <= stg_fault_q[i-1];
                stg_pc_q[i]    <= stg_pc_q[i-1];
                stg_data_q[i]  <= stg_data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            q_fault_q <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_inst_q[i] <= '0;
                q_pc_q[i]   <= ResetPc;
            end
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (enq) begin
                q_inst_q[wr_ptr_q]  <= stg_data_q[LAT-1];
                q_pc_q[wr_ptr_q]    <= stg_pc_q[LAT-1];
                q_fault_q[wr_ptr_q] <= stg_fault_q[LAT-1];
                wr_ptr_q            <= wr_ptr_q + PtrW'(1);
            end
            if (deq) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_inst  = q_inst_q[rd_ptr_q];
    assign bus.out_pc    = q_pc_q[rd_ptr_q];
    assign bus.out_fault = q_fault_q[rd_ptr_q];
endmodule

// File: tb/tb_imem_prefetch.sv
// Scoreboard bench for imem_prefetch: each reset/redirect pushes the expected
// sequential fetch stream; a negedge monitor pops and compares every transfer.
module tb_imem_prefetch;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 8;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned LAT      = 2;
    localparam int unsigned QDEPTH   = 4;
    localparam int unsigned RESET_PC = 0;
    localparam int          StreamLen = 40;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    imem_prefetch_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    imem_prefetch #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LAT     (LAT),
        .QDEPTH  (QDEPTH),
        .RESET_PC(RESET_PC)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [64];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // What a fetch of byte address pc must return, straight from the memory image.
    function automatic exp_t model_entry(input logic [7:0] pc);
        exp_t e;
        e.pc = pc;
        if (int'(pc[7:2]) < int'(DEPTH)) begin
            e.inst  = model_mem[pc[7:2]];
            e.fault = 1'b0;
        end else begin
            e.inst  = 32'h0;
            e.fault = 1'b1;
        end
        return e;
    endfunction

    task automatic push_stream(input logic [7:0] start);
        logic [7:0] pc;
        pc = start;
        exp_q.delete();
        for (int i = 0; i < StreamLen; i++) begin
            exp_q.push_back(model_entry(pc));
            pc = pc + 8'd4;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered and left just after a rising edge.
    task automatic redirect(input logic [7:0] addr, input logic do_wr, input logic [7:0] wa,
                            input logic [31:0] wd);
        bus.redir_valid = 1'b1;
        bus.redir_addr  = addr;
        bus.wr_en       = do_wr;
        bus.wr_addr     = wa;
        bus.wr_data     = wd;
        tick();
        bus.redir_valid = 1'b0;
        bus.wr_en       = 1'b0;
        if (do_wr && int'(wa[7:2]) < int'(DEPTH)) model_mem[wa[7:2]] = wd;
        push_stream(addr & 8'hFC);
        check("out_valid after redirect", 64'(bus.out_valid), 64'd0);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset out_valid", 64'(bus.out_valid), 64'd0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        push_stream(8'(RESET_PC));
    endtask

    task automatic expect_latency(input string name, input int req);
        int n;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check(name, 64'(n), 64'(req));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected output: pc 0x%0h with no expected entry", bus.out_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_pc", 64'(bus.out_pc), 64'(e.pc));
                    check("out_inst", 64'(bus.out_inst), 64'(e.inst));
                    check("out_fault", 64'(bus.out_fault), 64'(e.fault));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.redir_valid = 1'b0;
        bus.redir_addr  = '0;
        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.out_ready   = 1'b0;
        for (int i = 0; i < 64; i++) model_mem[i] = $urandom;

        // Load the array while held in reset; the low address bits are junk.
        tick();
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (i < 8) model_mem[i] = 32'h200f0008 + 32'(i);
            bus.wr_en   = 1'b1;
            bus.wr_addr = {6'(i), 2'($urandom_range(3))};
            bus.wr_data = model_mem[i];
            tick();
        end
        bus.wr_en = 1'b0;
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset out_inst", 64'(bus.out_inst), 64'd0);
        check("reset out_pc", 64'(bus.out_pc), 64'(RESET_PC));
        check("reset out_fault", 64'(bus.out_fault), 64'd0);

        // Back-to-back stream from reset.
        bus.out_ready = 1'b1;
        rst_n = 1'b1;
        push_stream(8'(RESET_PC));
        expect_latency("reset-to-first-valid cycles", int'(LAT) + 1);
        for (int i = 0; i < 8; i++) begin
            check("stream back-to-back valid", 64'(bus.out_valid), 64'd1);
            tick();
        end

        // Mid-stream reset, then a stalled consumer.
        bus.out_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (i >= int'(LAT) + 1) begin
                check("stall out_valid", 64'(bus.out_valid), 64'd1);
                check("stall head pc", 64'(bus.out_pc), 64'(RESET_PC));
            end
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < int'(QDEPTH); i++) begin
            check("drain no gap", 64'(bus.out_valid), 64'd1);
            tick();
        end

        // Redirect with the queue and pipeline both occupied.
        bus.out_ready = 1'b0;
        tick();
        redirect(8'h2B, 1'b0, 8'h00, 32'h0);
        bus.out_ready = 1'b1;
        expect_latency("redirect-to-first-valid cycles", int'(LAT) + 1);
        repeat (6) tick();

        // Run off the end of the array, then wrap the PC.
        redirect(8'h3C, 1'b0, 8'h00, 32'h0);
        repeat (10) tick();
        redirect(8'hFC, 1'b0, 8'h00, 32'h0);
        repeat (10) tick();

        // Write word 5 in the cycle pc 0x14 issues: old data first, new on refetch.
        redirect(8'h14, 1'b0, 8'h00, 32'h0);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 8'h15;
        bus.wr_data = 32'hAC0F0001;
        tick();
        bus.wr_en = 1'b0;
        model_mem[5] = 32'hAC0F0001;
        repeat (8) tick();
        redirect(8'h14, 1'b0, 8'h00, 32'h0);
        repeat (6) tick();
        check("refetched word 5 model", 64'(model_entry(8'h14).inst), 64'h00000000AC0F0001);

        // Random redirects, writes (some out of range), resets and back-pressure.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(7) == 0) begin
                do_reset();
            end else begin
                redirect(8'($urandom_range(255)), 1'b1, 8'($urandom_range(255)), $urandom);
            end
            repeat ($urandom_range(25, 5)) begin
                bus.out_ready = 1'($urandom_range(1));
                tick();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
